quadrant_selector: RTL and testbench

- Player-input stage directly upstream of the quadrant colour comparator.
- Turns five raw push-buttons into a debounced cursor position. Outputs the current quadrant as a 3-bit code and detects a correct selection against a target quadrant.
- Raises `win` for a fixed hold time after a correct selection. The comparator suppresses quadrant highlighting during that time.

---
 rtl/quad_pkg.sv | 58 +++++
 rtl/btn_debounce.sv | 49 ++++
 rtl/quadrant_selector.sv | 127 ++++++++++++
 tb/tb_quadrant_selector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared quadrant codes, FSM states and the cursor move table for the
// quadrant selector and the downstream colour comparator.
package quad_pkg;

    localparam logic [2:0] Q_NONE = 3'b000;
    localparam logic [2:0] Q_TL   = 3'b001;
    localparam logic [2:0] Q_TR   = 3'b010;
    localparam logic [2:0] Q_BL   = 3'b011;
    localparam logic [2:0] Q_BR   = 3'b100;

    localparam int BTN_SEL   = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;
    localparam int NUM_BTN   = 5;

    typedef enum logic {
        PLAY = 1'b0,
        WIN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_SEL,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    // Moves off the 2x2 grid edge leave the cursor where it is.
    function automatic logic [2:0] move_quad(input logic [2:0] q, input action_t act);
        logic [2:0] r;
        r = q;
        case (act)
            ACT_UP: begin
                if (q == Q_BL) r = Q_TL;
                else if (q == Q_BR) r = Q_TR;
            end
            ACT_DOWN: begin
                if (q == Q_TL) r = Q_BL;
                else if (q == Q_TR) r = Q_BR;
            end
            ACT_LEFT: begin
                if (q == Q_TR) r = Q_TL;
                else if (q == Q_BR) r = Q_BL;
            end
            ACT_RIGHT: begin
                if (q == Q_TL) r = Q_TR;
                else if (q == Q_BL) r = Q_BR;
            end
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The cycle that would bring the count to DEBOUNCE_CYCLES accepts the new level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level      = level_reg;
    assign rise_pulse = rise_reg;

endmodule

// File: rtl/quadrant_selector.sv
// Player input stage: debounced buttons drive a cursor over four quadrants,
// a select against the target either wins (timed hold) or counts a miss.
module quadrant_selector
    import quad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int WIN_HOLD_CYCLES = 25000000,
    parameter int MISS_W          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_sel,
    input  logic [2:0]        target,
    output logic [2:0]        cuadrante,
    output logic              win,
    output logic [MISS_W-1:0] miss_count
);

    localparam int HOLD_W = $clog2(WIN_HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD_CYCLES - 1);

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic               unused_levels;

    assign raw_btn = {btn_right, btn_left, btn_down, btn_up, btn_sel};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .rst_n     (rst_n),
                .raw       (raw_btn[gi]),
                .level     (btn_level[gi]),
                .rise_pulse(btn_rise[gi])
            );
        end
    endgenerate

    // Only the press edges drive this stage; held levels are not needed here.
    assign unused_levels = ^btn_level;

    action_t act;

    always_comb begin
        act = ACT_NONE;
        if (btn_rise[BTN_SEL])        act = ACT_SEL;
        else if (btn_rise[BTN_UP])    act = ACT_UP;
        else if (btn_rise[BTN_DOWN])  act = ACT_DOWN;
        else if (btn_rise[BTN_LEFT])  act = ACT_LEFT;
        else if (btn_rise[BTN_RIGHT]) act = ACT_RIGHT;
    end

    state_t            state_reg, state_next;
    logic [2:0]        cuad_reg, cuad_next;
    logic              win_reg, win_next;
    logic [MISS_W-1:0] miss_reg, miss_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              target_valid;

    assign target_valid = (target >= Q_TL) && (target <= Q_BR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= PLAY;
            cuad_reg  <= Q_TL;
            win_reg   <= 1'b0;
            miss_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cuad_reg  <= cuad_next;
            win_reg   <= win_next;
            miss_reg  <= miss_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cuad_next  = cuad_reg;
        win_next   = win_reg;
        miss_next  = miss_reg;
        hold_next  = hold_reg;
        case (state_reg)
            PLAY: begin
                if (act == ACT_SEL) begin
                    if (target_valid && (target == cuad_reg)) begin
                        state_next = WIN;
                        win_next   = 1'b1;
                        hold_next  = '0;
                    end else if (miss_reg != '1) begin
                        miss_next = miss_reg + MISS_W'(1);
                    end
                end else begin
                    cuad_next = move_quad(cuad_reg, act);
                end
            end
            WIN: begin
                // Button events are dropped here; the debouncers keep tracking.
                if (hold_reg == HOLD_LAST) begin
                    state_next = PLAY;
                    win_next   = 1'b0;
                    cuad_next  = Q_TL;
                    miss_next  = '0;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end
            default: state_next = PLAY;
        endcase
    end

    assign cuadrante  = cuad_reg;
    assign win        = win_reg;
    assign miss_count = miss_reg;

endmodule

// File: tb/tb_quadrant_selector.sv
// Directed bench for quadrant_selector with a grid/window reference model
// compared every cycle, plus hand-computed spot checks.
module tb_quadrant_selector;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int MW   = 4;
    localparam int MISS_MAX = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic          btn_left = 1'b0;
    logic          btn_right = 1'b0;
    logic          btn_sel = 1'b0;
    logic [2:0]    target = 3'd0;
    logic [2:0]    cuadrante;
    logic          win;
    logic [MW-1:0] miss_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    quadrant_selector #(
        .DEBOUNCE_CYCLES(DEB),
        .WIN_HOLD_CYCLES(HOLD),
        .MISS_W(MW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_sel   (btn_sel),
        .target    (target),
        .cuadrante (cuadrante),
        .win       (win),
        .miss_count(miss_count)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: a button press is accepted once the last DEB
    // synchronized samples all disagree with the accepted level; the cursor
    // is kept as (row, col) on a 2x2 grid; win is a countdown of remaining cycles.
    int          m_quad;
    int          m_miss;
    int          m_win_left;
    bit          m_valid = 1'b0;
    bit          m_level[5];
    bit          m_pend[5];
    logic [15:0] m_hist[5];

    task automatic model_step();
        logic [4:0] raw;
        int act;
        int row;
        int col;
        bit all_diff;
        raw = {btn_right, btn_left, btn_down, btn_up, btn_sel};
        if (!rst_n) begin
            m_quad = 1;
            m_miss = 0;
            m_win_left = 0;
            for (int b = 0; b < 5; b++) begin
                m_level[b] = 1'b0;
                m_pend[b] = 1'b0;
                m_hist[b] = '0;
            end
            m_valid = 1'b1;
            return;
        end
        act = -1;
        for (int b = 0; b < 5; b++) if (m_pend[b] && act < 0) act = b;
        if (m_win_left > 0) begin
            m_win_left--;
            if (m_win_left == 0) begin
                m_quad = 1;
                m_miss = 0;
            end
        end else if (act == 0) begin
            if (target >= 3'd1 && target <= 3'd4 && int'(target) == m_quad) m_win_left = HOLD;
            else if (m_miss < MISS_MAX) m_miss++;
        end else if (act > 0) begin
            row = (m_quad - 1) / 2;
            col = (m_quad - 1) % 2;
            case (act)
                1: row = 0;
                2: row = 1;
                3: col = 0;
                4: col = 1;
                default: ;
            endcase
            m_quad = row * 2 + col + 1;
        end
        for (int b = 0; b < 5; b++) begin
            m_pend[b] = 1'b0;
            all_diff = 1'b1;
            for (int i = 1; i <= DEB; i++) if (m_hist[b][i] == m_level[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[b] = !m_level[b];
                m_pend[b] = m_level[b];
            end
            m_hist[b] = {m_hist[b][14:0], raw[b]};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("cyc_cuadrante", 32'(cuadrante), 32'(m_quad));
            check("cyc_win", 32'(win), 32'(m_win_left > 0));
            check("cyc_miss", 32'(miss_count), 32'(m_miss));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input bit v);
        case (b)
            0: btn_sel = v;
            1: btn_up = v;
            2: btn_down = v;
            3: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(DEB + 3);
        set_btn(b, 1'b0);
        tick(DEB + 5);
    endtask

    task automatic press_expect(input string name, input int b, input int exp_quad);
        press(b);
        check(name, 32'(cuadrante), 32'(exp_quad));
        $display("txn %s: cuadrante=%0d", name, cuadrante);
    endtask

    int win_cnt;
    logic [2:0] bad_targets [4];

    initial begin
        bad_targets[0] = 3'd0;
        bad_targets[1] = 3'd3;
        bad_targets[2] = 3'd5;
        bad_targets[3] = 3'd7;

        tick(3);
        rst_n = 1'b1;
        check("reset_cuad", 32'(cuadrante), 32'd1);
        check("reset_win", 32'(win), 32'd0);
        check("reset_miss", 32'(miss_count), 32'd0);
        $display("txn reset: cuadrante=%0d win=%0d miss=%0d", cuadrante, win, miss_count);

        btn_right = 1'b1;
        tick(6);
        check("right_at_6", 32'(cuadrante), 32'd1);
        tick(1);
        check("right_at_7", 32'(cuadrante), 32'd2);
        tick(3);
        btn_right = 1'b0;
        tick(DEB + 5);
        $display("txn right: cuadrante=%0d", cuadrante);

        press_expect("back_left", 3, 1);

        btn_down = 1'b1; tick(2);
        btn_down = 1'b0; tick(2);
        btn_down = 1'b1; tick(2);
        btn_down = 1'b0; tick(12);
        check("bounce_cuad", 32'(cuadrante), 32'd1);
        $display("txn bounce: cuadrante=%0d", cuadrante);

        press_expect("edge_up", 1, 1);
        press_expect("edge_left", 3, 1);
        press_expect("walk_down", 2, 3);
        press_expect("walk_right", 4, 4);
        press_expect("walk_up", 1, 2);
        press_expect("walk_left", 3, 1);

        target = 3'd3;
        btn_sel = 1'b1;
        btn_down = 1'b1;
        tick(DEB + 3);
        btn_sel = 1'b0;
        btn_down = 1'b0;
        tick(DEB + 5);
        check("simul_miss", 32'(miss_count), 32'd1);
        check("simul_cuad", 32'(cuadrante), 32'd1);
        $display("txn simultaneous: cuadrante=%0d miss=%0d", cuadrante, miss_count);

        for (int i = 0; i < 17; i++) begin
            target = bad_targets[i % 4];
            press(0);
            $display("txn wrong_sel %0d target=%0d: miss=%0d", i, target, miss_count);
        end
        check("miss_sat", 32'(miss_count), 32'd15);

        press_expect("to_bl", 2, 3);
        press_expect("to_br", 4, 4);

        target = 3'd4;
        btn_sel = 1'b1;
        win_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (c == DEB + 2) btn_sel = 1'b0;
            if (win) begin
                win_cnt++;
                if (win_cnt == 1) btn_up = 1'b1;
                if (win_cnt == 8) btn_up = 1'b0;
            end
        end
        check("win_cycles", 32'(win_cnt), 32'(HOLD));
        check("after_win_cuad", 32'(cuadrante), 32'd1);
        check("after_win_miss", 32'(miss_count), 32'd0);
        $display("txn win: cycles=%0d cuadrante=%0d miss=%0d", win_cnt, cuadrante, miss_count);

        target = 3'd1;
        btn_sel = 1'b1;
        tick(DEB + 3);
        btn_sel = 1'b0;
        check("win2_entered", 32'(win), 32'd1);
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("midwin_rst_win", 32'(win), 32'd0);
        check("midwin_rst_cuad", 32'(cuadrante), 32'd1);
        tick(4);
        rst_n = 1'b1;
        tick(25);
        check("post_rst_win", 32'(win), 32'd0);
        check("post_rst_cuad", 32'(cuadrante), 32'd1);
        $display("txn reset_mid_win: win=%0d cuadrante=%0d", win, cuadrante);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
